// File: rtl/instr_decode_buf.sv
// instr_decode_buf: two-entry (main + skid) buffer that splits a 32-bit
// instruction word into opcode/rd/rs/imm fields and an unsigned-immediate
// flag at acceptance time. The output registers hold the main entry. The
// skid entry absorbs one extra beat, which lets in_ready be a flop.
module instr_decode_buf #(
    parameter logic [63:0] UNSIGNED_MASK = 64'h0000_0000_0000_FF00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_opcode,
    output logic [3:0]  out_rd,
    output logic [3:0]  out_rs,
    output logic [17:0] out_imm,
    output logic        out_u
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [17:0] imm;
        logic        u;
    } entry_t;

    state_t state;
    state_t next_state;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_dec;

    logic accept;
    logic consume;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    // Decode the incoming word once; only stored results are presented.
    always_comb begin
        in_dec        = '0;
        in_dec.opcode = in_instr[31:26];
        in_dec.rd     = in_instr[25:22];
        in_dec.rs     = in_instr[21:18];
        in_dec.imm    = in_instr[17:0];
        in_dec.u      = UNSIGNED_MASK[in_instr[31:26]];
    end

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    // Next-state logic and per-entry load enables; flush wins over every handshake.
    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        next_state   = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        next_state   = ONE;
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        next_state = FULL;
                        load_skid  = 1'b1;
                    end else if (consume) begin
                        next_state = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        next_state     = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    // State register and registered in_ready, derived from next_state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != FULL);
        end
    end

    // Entry storage: main takes a fresh word or the skid entry. Neither
    // changes on a discard or a drain to EMPTY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_dec;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_dec;
            end
        end
    end

    assign out_opcode = main_q.opcode;
    assign out_rd     = main_q.rd;
    assign out_rs     = main_q.rs;
    assign out_imm    = main_q.imm;
    assign out_u      = main_q.u;

endmodule

// File: tb/tb_instr_decode_buf.sv
// Directed/scoreboard bench for instr_decode_buf.
// Each accepted word's expected decode is pushed to a queue.
// While the DUT shows a valid entry, the queue head is compared to it.
module tb_instr_decode_buf;

    localparam logic [63:0] MASK = 64'h0000_0000_0000_FF00;
    localparam logic [31:0] WA   = 32'h2CD60084;
    localparam logic [31:0] WB   = 32'h044BFFFF;
    localparam logic [31:0] WC   = 32'hFC3A5A5A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_opcode;
    logic [3:0]  out_rd;
    logic [3:0]  out_rs;
    logic [17:0] out_imm;
    logic        out_u;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [32:0] sb[$];
    logic [63:0] mask_v = MASK;

    instr_decode_buf #(.UNSIGNED_MASK(MASK)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs),
        .out_imm(out_imm), .out_u(out_u)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] decode(input logic [31:0] w);
        return {w[31:26], w[25:22], w[21:18], w[17:0], mask_v[w[31:26]]};
    endfunction

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check outputs, update scoreboard, advance past the edge.
    task automatic step(input logic v, input logic [31:0] w, input logic ordy,
                        input logic fl, input logic rst, input string tag);
        logic [32:0] obs;
        rst_n     = rst;
        flush     = fl;
        in_valid  = v;
        in_instr  = w;
        out_ready = ordy;
        #3;
        obs = {out_opcode, out_rd, out_rs, out_imm, out_u};
        chk({tag, ".out_valid"}, 33'(out_valid), 33'(sb.size() != 0));
        chk({tag, ".in_ready"}, 33'(in_ready), 33'(sb.size() < 2));
        if (sb.size() != 0) begin
            chk({tag, ".fields"}, obs, sb[0]);
            if (ordy) void'(sb.pop_front());
        end
        if (v && sb.size() < 2 && !(sb.size() == 2)) begin
            // Acceptance is judged from the pre-pop occupancy.
        end
        @(posedge clk);
        #1;
    endtask

    // Wrapper that keeps acceptance prediction out of step's pop ordering.
    task automatic beat(input logic v, input logic [31:0] w, input logic ordy,
                        input logic fl, input logic rst, input string tag);
        int unsigned occ;
        occ = sb.size();
        step(v, w, ordy, fl, rst, tag);
        if (!rst || fl) begin
            sb.delete();
        end else if (v && occ < 2) begin
            sb.push_back(decode(w));
        end
        if (!rst) begin
            chk({tag, ".rst_valid"}, 33'(out_valid), 33'd0);
            chk({tag, ".rst_ready"}, 33'(in_ready), 33'd1);
            chk({tag, ".rst_fields"}, {out_opcode, out_rd, out_rs, out_imm, out_u}, 33'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        beat(1'b0, '0, 1'b0, 1'b0, 1'b0, "reset");

        // Accept on first edge out of reset, single words with immediate consume
        beat(1'b1, WA, 1'b1, 1'b0, 1'b1, "a_in");
        chk("a_opcode", 33'(out_opcode), 33'h0B);
        chk("a_rd", 33'(out_rd), 33'd3);
        chk("a_rs", 33'(out_rs), 33'd5);
        chk("a_imm", 33'(out_imm), 33'h20084);
        chk("a_u", 33'(out_u), 33'd1);
        beat(1'b0, '0, 1'b1, 1'b0, 1'b1, "a_out");
        beat(1'b0, '0, 1'b1, 1'b0, 1'b1, "a_idle");
        beat(1'b1, WB, 1'b1, 1'b0, 1'b1, "b_in");
        chk("b_opcode", 33'(out_opcode), 33'h01);
        chk("b_rd", 33'(out_rd), 33'd1);
        chk("b_rs", 33'(out_rs), 33'd2);
        chk("b_imm", 33'(out_imm), 33'h3FFFF);
        chk("b_u", 33'(out_u), 33'd0);
        beat(1'b0, '0, 1'b1, 1'b0, 1'b1, "b_out");

        // Backpressure into FULL, hold, then drain in order
        beat(1'b1, WA, 1'b0, 1'b0, 1'b1, "bp_a");
        beat(1'b1, WB, 1'b0, 1'b0, 1'b1, "bp_b");
        beat(1'b1, WC, 1'b0, 1'b0, 1'b1, "bp_full");
        beat(1'b0, '0, 1'b0, 1'b0, 1'b1, "bp_hold");
        beat(1'b0, '0, 1'b1, 1'b0, 1'b1, "bp_drain_a");
        beat(1'b0, '0, 1'b1, 1'b0, 1'b1, "bp_drain_b");
        beat(1'b0, '0, 1'b1, 1'b0, 1'b1, "bp_empty");

        // Streaming: one word per cycle
        for (int i = 0; i < 8; i++)
            beat(1'b1, {6'(i), 4'(i), 4'(7 - i), 18'(32'h1F000 + 32'(i))}, 1'b1, 1'b0, 1'b1, "stream");
        beat(1'b0, '0, 1'b1, 1'b0, 1'b1, "stream_end");

        // Flush while FULL with in_valid, and while ONE with an accepted beat
        beat(1'b1, WA, 1'b0, 1'b0, 1'b1, "fl_a");
        beat(1'b1, WB, 1'b0, 1'b0, 1'b1, "fl_b");
        beat(1'b1, WC, 1'b0, 1'b1, 1'b1, "fl_full");
        beat(1'b0, '0, 1'b1, 1'b0, 1'b1, "fl_after");
        beat(1'b1, WA, 1'b0, 1'b0, 1'b1, "fl_one");
        beat(1'b1, WC, 1'b1, 1'b1, 1'b1, "fl_acc");
        beat(1'b0, '0, 1'b1, 1'b0, 1'b1, "fl_after2");

        // Reset while FULL, then normal traffic
        beat(1'b1, WB, 1'b0, 1'b0, 1'b1, "rs_a");
        beat(1'b1, WA, 1'b0, 1'b0, 1'b1, "rs_b");
        beat(1'b1, WC, 1'b1, 1'b1, 1'b0, "rs_full");
        beat(1'b1, WB, 1'b1, 1'b0, 1'b1, "rs_next");
        beat(1'b0, '0, 1'b1, 1'b0, 1'b1, "rs_out");

        // Random traffic
        for (int i = 0; i < 60; i++)
            beat(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0), 1'b1, "rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
